// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed seven-segment scan driver with hex decode and leading-zero blanking
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset (display dark while low)
//   digits_in  hex nibbles, nibble i = bits [4i+3:4i], digit 0 rightmost
//   load       capture strobe for digits_in (and dp_in when built)
//   blank_lz   1 = suppress leading zeros
//   dp_in      decimal points, 1 = lit (SEVEN_SEG_DP_EN builds only)
//   dp         decimal point, active-low, registered with seg (SEVEN_SEG_DP_EN builds only)
//   seg[0:6]   segments a..g, seg[0]=a, active-low
//   an         digit enables, active-low, one-hot-low
//
// Optional feature macro: SEVEN_SEG_DP_EN (decimal-point support).

module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    input  logic                      blank_lz,
`ifdef SEVEN_SEG_DP_EN
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic                      dp,
`endif
    output logic [0:6]                seg,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    tick;

    logic [3:0]              cur_nib;
    logic                    upper_nz;
    logic                    blank;
    logic [0:6]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

`ifdef SEVEN_SEG_DP_EN
    logic [NUM_DIGITS-1:0]   dp_shadow;
`endif

    // Segment patterns listed a..g left to right, matching seg[0:6].
    function automatic logic [0:6] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign tick = (presc == LAST_PRESC);

    // Everything feeding the output registers is derived from the shadow
    // copy in one go, so a load landing on a tick edge can only affect the
    // following digit, never half of the current one.
    always_comb begin
        cur_nib  = shadow[{idx, 2'b00} +: 4];
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && shadow[4*j +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        // Digit 0 is never blanked so an all-zero value still reads "0".
        blank = blank_lz && (idx != '0) && !upper_nz;
`ifdef SEVEN_SEG_DP_EN
        if (dp_shadow[idx]) begin
            blank = 1'b0;
        end
`endif
        seg_next = blank ? 7'b1111111 : hex7(cur_nib);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            an_next[j] = (idx != IW'(j));
        end
    end

    // Outputs latch the current index on the tick while the index moves on,
    // so the first tick after reset lights digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            presc  <= '0;
            idx    <= '0;
            an     <= '1;
            seg    <= 7'b1111111;
        end else begin
            if (load) begin
                shadow <= digits_in;
            end
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                an  <= an_next;
                seg <= seg_next;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_DP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_shadow <= '0;
            dp        <= 1'b1;
        end else begin
            if (load) begin
                dp_shadow <= dp_in;
            end
            if (tick) begin
                dp <= ~dp_shadow[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver

module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic        blank_lz;
    logic [0:6]  seg;
    logic [3:0]  an;
`ifdef SEVEN_SEG_DP_EN
    logic [3:0]  dp_in;
    logic        dp;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] BLANK = 7'b1111111;

    seven_seg_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_in (digits_in),
        .load      (load),
        .blank_lz  (blank_lz),
`ifdef SEVEN_SEG_DP_EN
        .dp_in     (dp_in),
        .dp        (dp),
`endif
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one full digit period (4 clocks), optionally loading at its first edge.
    task automatic next_digit(input logic do_load, input logic [15:0] val);
        if (do_load) begin
            digits_in = val;
            load      = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_an", 16'(an), 16'hF);
        check("reset_seg", 16'(seg), 16'(BLANK));
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("pre_tick_an", 16'(an), 16'hF);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        digits_in = 16'h0000;
        load      = 1'b0;
        blank_lz  = 1'b0;
`ifdef SEVEN_SEG_DP_EN
        dp_in     = 4'b0000;
`endif

        // Reset release and scan order.
        release_reset();
        check("first_an", 16'(an), 16'hE);
        check("first_seg", 16'(seg), 16'(7'b0000001));
        next_digit(1'b0, 16'h0);
        check("scan_an1", 16'(an), 16'hD);
        next_digit(1'b0, 16'h0);
        check("scan_an2", 16'(an), 16'hB);
        next_digit(1'b0, 16'h0);
        check("scan_an3", 16'(an), 16'h7);
        next_digit(1'b0, 16'h0);
        check("scan_wrap_an", 16'(an), 16'hE);

        // Plain hex decode of A3F0.
        next_digit(1'b1, 16'hA3F0);
        check("a3f0_an1", 16'(an), 16'hD);
        check("a3f0_seg1", 16'(seg), 16'(7'b0111000));
        next_digit(1'b0, 16'h0);
        check("a3f0_seg2", 16'(seg), 16'(7'b0000110));
        next_digit(1'b0, 16'h0);
        check("a3f0_seg3", 16'(seg), 16'(7'b0001000));
        next_digit(1'b0, 16'h0);
        check("a3f0_seg0", 16'(seg), 16'(7'b0000001));

        // Leading-zero blanking of 0007.
        blank_lz = 1'b1;
        next_digit(1'b1, 16'h0007);
        check("lz7_an1", 16'(an), 16'hD);
        check("lz7_seg1", 16'(seg), 16'(BLANK));
        next_digit(1'b0, 16'h0);
        check("lz7_an2", 16'(an), 16'hB);
        check("lz7_seg2", 16'(seg), 16'(BLANK));
        next_digit(1'b0, 16'h0);
        check("lz7_an3", 16'(an), 16'h7);
        check("lz7_seg3", 16'(seg), 16'(BLANK));
        next_digit(1'b0, 16'h0);
        check("lz7_seg0", 16'(seg), 16'(7'b0001111));

        // All-zero value keeps digit 0 lit.
        next_digit(1'b1, 16'h0000);
        check("lz0_seg1", 16'(seg), 16'(BLANK));
        next_digit(1'b0, 16'h0);
        check("lz0_seg2", 16'(seg), 16'(BLANK));
        next_digit(1'b0, 16'h0);
        check("lz0_seg3", 16'(seg), 16'(BLANK));
        next_digit(1'b0, 16'h0);
        check("lz0_seg0", 16'(seg), 16'(7'b0000001));

        // digits_in change without load must not reach the display.
        digits_in = 16'hFFFF;
        next_digit(1'b0, 16'h0);
        check("noload_seg1", 16'(seg), 16'(BLANK));

        // Load on the tick edge: digit 2 still from old value, then new value.
        repeat (3) @(negedge clk);
        digits_in = 16'h1234;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("tickload_an2", 16'(an), 16'hB);
        check("tickload_seg2", 16'(seg), 16'(BLANK));
        next_digit(1'b0, 16'h0);
        check("tickload_seg3", 16'(seg), 16'(7'b1001111));
        next_digit(1'b0, 16'h0);
        check("tickload_seg0", 16'(seg), 16'(7'b1001100));

        // Asynchronous reset mid-scan.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_an", 16'(an), 16'hF);
        check("midrst_seg", 16'(seg), 16'(BLANK));

`ifdef SEVEN_SEG_DP_EN
        check("dp_reset", 16'(dp), 16'h1);
        @(negedge clk);
        release_reset();
        blank_lz = 1'b1;
        dp_in    = 4'b0100;
        next_digit(1'b1, 16'h0000);
        check("dp_seg1", 16'(seg), 16'(BLANK));
        check("dp_dp1", 16'(dp), 16'h1);
        next_digit(1'b0, 16'h0);
        check("dp_an2", 16'(an), 16'hB);
        check("dp_seg2", 16'(seg), 16'(7'b0000001));
        check("dp_dp2", 16'(dp), 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit is displayed (min 2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 digits_in  input  4*NUM_DIGITS  hex nibbles; nibble i = bits [4i+3:4i], digit 0 rightmost.
REQ-007 load  input  1  capture strobe for digits_in.
REQ-008 blank_lz  input  1  1 = suppress leading zeros.
REQ-009 seg  output  7 [0:6]  segments a..g, seg[0]=a, active-low.
REQ-010 an  output  NUM_DIGITS  digit enables, active-low, one-hot-low.

Function
REQ-011 load=1 at a rising edge SHALL copy digits_in into an internal shadow register; shadow SHALL hold otherwise.
REQ-012 Displayed values SHALL come only from the shadow register, never directly from digits_in.
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; a tick SHALL occur on the cycle it equals SCAN_DIV-1.
REQ-014 Digit index SHALL advance by 1 on each tick, wrapping NUM_DIGITS-1 -> 0.
REQ-015 an and seg SHALL be registered; both SHALL change in the same cycle, one cycle after the tick.
REQ-016 an SHALL drive exactly bit [index] low; all other bits high.
REQ-017 Hex decode (seg[0:6]): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
REQ-018 Hex decode continued: 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-019 With blank_lz=1, digit i SHALL show seg=1111111 when its nibble and all higher nibbles are 0, except digit 0 which is never blanked.
REQ-020 Blanked digits SHALL still be scanned (an low) so brightness duty is uniform.
REQ-021 load coinciding with a tick SHALL display the newly captured value starting from the next index update after capture; no mixed-nibble output SHALL occur.
REQ-022 blank_lz SHALL be sampled combinationally with the shadow value at the segment register input.

Reset
REQ-023 rst_n low SHALL immediately set shadow=0, prescaler=0, index=0.
REQ-024 During reset an SHALL be all 1s and seg SHALL be 1111111 (display dark).
REQ-025 First tick after rst_n release SHALL occur SCAN_DIV cycles later; an/seg update one cycle after it to digit 0.
REQ-026 Reset mid-scan SHALL abandon the current digit with no glitch beyond the asynchronous dark state.

Configuration
REQ-027 Macro SEVEN_SEG_DP_EN SHALL compile in decimal-point support.
REQ-028 With SEVEN_SEG_DP_EN: input dp_in [NUM_DIGITS-1:0] (1 = point lit) captured on load; output dp active-low, registered alongside seg, reset value 1.
REQ-029 With SEVEN_SEG_DP_EN, a digit with dp lit SHALL NOT be leading-zero-blanked.
REQ-030 Without SEVEN_SEG_DP_EN: no dp_in or dp ports, no related logic.

Verification
REQ-031 Reset release, SCAN_DIV=4, NUM_DIGITS=4 -> an steps 1110,1101,1011,0111,1110 every 4 cycles; first change at cycle 5.
REQ-032 load digits_in=16'hA3F0, blank_lz=0 -> digit0 seg=0000001, digit1 0111000, digit2 0000110, digit3 0001000.
REQ-033 load 16'h0007, blank_lz=1 -> digits 3..1 seg=1111111 with an still low in turn, digit0 seg=0001111.
REQ-034 load 16'h0000, blank_lz=1 -> digit0 seg=0000001, others 1111111.
REQ-035 change digits_in without load -> display unchanged; load coincident with tick -> new value shown from the next index onward, no mixed nibbles.
REQ-036 Assert rst_n mid-scan -> an=1111, seg=1111111 same cycle; SEVEN_SEG_DP_EN build, dp_in=4'b0100 with 16'h0000, blank_lz=1 -> digit2 seg=0000001, dp=0.
